icache_controller: RTL and testbench
====================================

ICACHE_CONTROLLER -- requirements
Module: icache_controller

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed by shared-package constants: LINES=8, LINE_W=128, TAG_W=3, INDEX_W=3, OFFSET_W=2.
REQ-002 CLK  input  1  sole clock, all state on rising edge.
REQ-003 RESET_N  input  1  asynchronous, active-low reset.
REQ-004 PC  input  32  CPU fetch address; bits [9:2] used, [31:10] and [1:0] ignored.
REQ-005 CPU_READ  input  1  CPU fetch request, held high with stable PC while BUSYWAIT=1.
REQ-006 INSTRUCTION  output  32  fetched instruction word.
REQ-007 BUSYWAIT  output  1  CPU stall; the CPU SHALL hold PC while high.
REQ-008 MEM_READ  output  1  block read request to instruction memory.
REQ-009 MEM_ADDRESS  output  6  block address (PC[9:4]) to instruction memory.
REQ-010 MEM_READDATA  input  128  4-word block from memory, word 0 in bits [31:0].
REQ-011 MEM_BUSYWAIT  input  1  memory busy; high while a read is in progress.

Function
REQ-012 Address split SHALL be: offset=PC[3:2], index=PC[6:4], tag=PC[9:7]; direct-mapped, read-only.
REQ-013 Hit = CPU_READ & valid[index] & (tag[index]==PC tag), evaluated combinationally.
REQ-014 INSTRUCTION SHALL combinationally equal word [offset] of line [index]; value is meaningful only when hit.
REQ-015 BUSYWAIT SHALL be 1 when state!=IDLE, or in IDLE when CPU_READ=1 and not hit; 0 otherwise (including CPU_READ=0).
REQ-016 FSM states: IDLE, REQ, WAIT, UPDATE.
REQ-017 IDLE: on miss at a rising edge, latch PC[9:4] into a fill-address register and go to REQ; on hit or CPU_READ=0, stay.
REQ-018 REQ: MEM_READ=1, MEM_ADDRESS=fill address; go to WAIT on the edge MEM_BUSYWAIT=1 is sampled, else stay.
REQ-019 WAIT: MEM_READ=1; on the edge MEM_BUSYWAIT=0 is sampled, capture MEM_READDATA into a fill buffer and go to UPDATE.
REQ-020 UPDATE: MEM_READ=0; at the edge write fill buffer to line [fill index], set tag, set valid, go to IDLE.
REQ-021 Miss latency SHALL be: BUSYWAIT deasserts combinationally in the first IDLE cycle after UPDATE (line now hits); minimum miss penalty = memory cycles + 3.
REQ-022 MEM_READ SHALL be 0 in IDLE and UPDATE; MEM_ADDRESS SHALL hold the fill address in all states.
REQ-023 PC changes while state!=IDLE SHALL NOT alter the fill; fill uses only the latched address.
REQ-024 Only the filled line SHALL change; all other lines' valid/tag/data unchanged.
REQ-025 A refill of a valid line with a different tag SHALL overwrite it (no write-back, read-only cache).

Reset
REQ-026 RESET_N=0 SHALL immediately force state=IDLE, all valid bits=0, MEM_READ=0, fill address=0, fill buffer=0, regardless of clock.
REQ-027 Tag and data arrays SHALL NOT be reset.
REQ-028 Reset asserted during REQ/WAIT/UPDATE SHALL abort the fill; no line becomes valid.
REQ-029 After reset, BUSYWAIT SHALL be 1 whenever CPU_READ=1 (all misses), 0 otherwise.

Structure
REQ-030 Shared package SHALL hold the state enumeration and the geometry constants of REQ-001.
REQ-031 One sub-module icache_word_mux (4:1, 32-bit, combinational, selected by offset) SHALL produce INSTRUCTION.
REQ-032 Valid, tag and data arrays, FSM and fill registers SHALL reside in icache_controller.

Verification
REQ-033 Reset, CPU_READ=1, PC=0x000 -> BUSYWAIT=1 same cycle, REQ next edge, MEM_READ=1, MEM_ADDRESS=6'h00.
REQ-034 Memory busy 5 cycles returning 128'h0000000D_0000000C_0000000B_0000000A -> UPDATE then IDLE; PC=0x000,0x004,0x008,0x00C give 0xA,0xB,0xC,0xD with BUSYWAIT=0.
REQ-035 After line 0 fill, PC=0x080 (same index, tag 1) -> miss, MEM_ADDRESS=6'h08; afterwards PC=0x000 misses again.
REQ-036 PC toggled to 0x3F0 during WAIT of a fill for 0x010 -> MEM_ADDRESS stays 6'h01, only line 1 becomes valid.
REQ-037 RESET_N pulsed low mid-WAIT -> MEM_READ=0 immediately, state IDLE, subsequent fetch of same PC misses.
REQ-038 CPU_READ=0 with any PC after reset -> BUSYWAIT=0, MEM_READ=0, no state change.

Source files
------------

// File: rtl/icache_controller_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
package icache_controller_pkg;

    localparam int LINES      = 8;
    localparam int LINE_W     = 128;
    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;
    localparam int BLOCK_W    = TAG_W + INDEX_W;
    localparam int PC_MSB     = BYTE_OFF_W + OFFSET_W + BLOCK_W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UPDATE
    } state_e;

endpackage

// File: rtl/icache_word_mux.sv
// Selects one 32-bit instruction word out of a 128-bit cache line.
module icache_word_mux
    import icache_controller_pkg::*;
(
    input  logic [LINE_W-1:0]   i_line,
    input  logic [OFFSET_W-1:0] i_offset,
    output logic [WORD_W-1:0]   o_word
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_word and no latch is inferred.
        o_word = '0;
        case (i_offset)
            2'd0: o_word = i_line[0*WORD_W +: WORD_W];
            2'd1: o_word = i_line[1*WORD_W +: WORD_W];
            2'd2: o_word = i_line[2*WORD_W +: WORD_W];
            2'd3: o_word = i_line[3*WORD_W +: WORD_W];
            default: o_word = '0;
        endcase
    end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache: 8 lines of 4 words, one
// outstanding block fill at a time from instruction memory.
module icache_controller
    import icache_controller_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic [31:0]         PC,
    input  logic                CPU_READ,
    output logic [WORD_W-1:0]   INSTRUCTION,
    output logic                BUSYWAIT,
    output logic                MEM_READ,
    output logic [BLOCK_W-1:0]  MEM_ADDRESS,
    input  logic [LINE_W-1:0]   MEM_READDATA,
    input  logic                MEM_BUSYWAIT
);

    state_e              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [LINE_W-1:0]   r_data [LINES];
    logic [BLOCK_W-1:0]  r_fill_addr;
    logic [LINE_W-1:0]   r_fill_buf;
    logic                r_mem_read;

    logic [OFFSET_W-1:0] w_offset;
    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_fill_index;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_hit;
    logic                w_unused_pc;

    assign w_offset     = PC[BYTE_OFF_W +: OFFSET_W];
    assign w_index      = PC[BYTE_OFF_W + OFFSET_W +: INDEX_W];
    assign w_tag        = PC[BYTE_OFF_W + OFFSET_W + INDEX_W +: TAG_W];
    assign w_unused_pc  = ^{PC[31:PC_MSB+1], PC[BYTE_OFF_W-1:0]};

    assign w_fill_index = r_fill_addr[INDEX_W-1:0];
    assign w_fill_tag   = r_fill_addr[BLOCK_W-1 -: TAG_W];

    assign w_hit        = CPU_READ & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign BUSYWAIT     = (r_state != S_IDLE) | (CPU_READ & ~w_hit);
    assign MEM_READ     = r_mem_read;
    assign MEM_ADDRESS  = r_fill_addr;

    // Control state: the fill only ever uses the latched block address, so
    // PC may wander while a fill is in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_fill_addr <= '0;
            r_fill_buf  <= '0;
            r_mem_read  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (CPU_READ && !w_hit) begin
                        r_fill_addr <= PC[PC_MSB -: BLOCK_W];
                        r_mem_read  <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (MEM_BUSYWAIT) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!MEM_BUSYWAIT) begin
                        r_fill_buf <= MEM_READDATA;
                        r_mem_read <= 1'b0;
                        r_state    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_valid[w_fill_index] <= 1'b1;
                    r_state               <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone qualify its contents.
    always_ff @(posedge CLK) begin
        if (r_state == S_UPDATE) begin
            r_data[w_fill_index] <= r_fill_buf;
            r_tag[w_fill_index]  <= w_fill_tag;
        end
    end

    icache_word_mux u_word_mux (
        .i_line   (r_data[w_index]),
        .i_offset (w_offset),
        .o_word   (INSTRUCTION)
    );

endmodule

// File: tb/tb_icache_controller.sv
// Randomized scoreboard bench for icache_controller with a behavioural
// cache/memory reference model.
module tb_icache_controller;

    logic         CLK;
    logic         RESET_N;
    logic [31:0]  PC;
    logic         CPU_READ;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    icache_controller dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PC           (PC),
        .CPU_READ     (CPU_READ),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] mem [64];
    int           mem_lat = 5;
    int           mem_cnt = 0;

    bit           m_valid [8];
    logic [2:0]   m_tag   [8];
    logic [31:0]  exp_q   [$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [127:0] blk;
        blk = mem[pc[9:4]];
        return blk[32*pc[3:2] +: 32];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    // Instruction memory: busy for mem_lat cycles after it sees a read request.
    initial begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (mem_cnt != 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    MEM_BUSYWAIT = 1'b0;
                    MEM_READDATA = mem[MEM_ADDRESS];
                end
            end else if (MEM_READ) begin
                MEM_BUSYWAIT = 1'b1;
                MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
                mem_cnt      = mem_lat;
            end
        end
    end

    // Monitor: every granted fetch is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (RESET_N && CPU_READ && !BUSYWAIT) begin
                check("queue_depth", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) check("instruction", INSTRUCTION, exp_q.pop_front());
            end
        end
    end

    // mode 0: plain fetch, 1: toggle PC during the fill, 2: reset mid-fill
    task automatic fetch(input logic [31:0] pc, input int mode);
        logic [2:0] idx;
        logic [2:0] tg;
        bit         miss;
        bit         exact;
        bit         toggled;
        int         busy;
        idx     = pc[6:4];
        tg      = pc[9:7];
        miss    = !(m_valid[idx] && m_tag[idx] == tg);
        toggled = 1'b0;
        @(negedge CLK);
        PC       = pc;
        CPU_READ = 1'b1;
        exp_q.push_back(mem_word(pc));
        #2;
        exact = (mem_cnt == 0) && !MEM_BUSYWAIT;
        check("first_busywait", 32'(BUSYWAIT), 32'(miss));
        check("idle_mem_read", 32'(MEM_READ), 32'd0);
        busy = 0;
        while (BUSYWAIT && busy < 200) begin
            busy++;
            @(negedge CLK);
            if (mode == 1 && toggled) PC = pc;
            #2;
            if (MEM_READ) check("mem_address", 32'(MEM_ADDRESS), 32'(pc[9:4]));
            if (mode == 1 && !toggled && MEM_READ && MEM_BUSYWAIT) begin
                PC      = 32'h0000_03F0;
                toggled = 1'b1;
            end
            if (mode == 2 && MEM_READ && MEM_BUSYWAIT && busy >= 3) begin
                RESET_N = 1'b0;
                #1;
                check("abort_mem_read", 32'(MEM_READ), 32'd0);
                check("abort_mem_address", 32'(MEM_ADDRESS), 32'd0);
                #1;
                RESET_N  = 1'b1;
                CPU_READ = 1'b0;
                void'(exp_q.pop_back());
                model_reset();
                return;
            end
        end
        if (busy >= 200) begin
            check("fetch_timeout", 32'(busy), 32'd0);
            void'(exp_q.pop_back());
        end else if (miss && exact) begin
            check("miss_penalty", 32'(busy), 32'(mem_lat + 3));
        end
        if (miss) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        @(negedge CLK);
        CPU_READ = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        #2;
        check("reset_mem_read", 32'(MEM_READ), 32'd0);
        check("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        RESET_N  = 1'b0;
        CPU_READ = 1'b0;
        PC       = '0;
        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[0] = 128'h0000000D_0000000C_0000000B_0000000A;
        model_reset();
        repeat (2) @(negedge CLK);
        #2;
        check("reset_busywait", 32'(BUSYWAIT), 32'd0);
        check("reset_mem_read", 32'(MEM_READ), 32'd0);
        check("reset_mem_address", 32'(MEM_ADDRESS), 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Idle fetches with CPU_READ low must not stall or request memory.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            PC = $urandom;
            #2;
            check("noread_busywait", 32'(BUSYWAIT), 32'd0);
            check("noread_mem_read", 32'(MEM_READ), 32'd0);
        end

        // Line 0 fill with 5-cycle memory, then the four words hit.
        mem_lat = 5;
        fetch(32'h0000_0000, 0);
        fetch(32'h0000_0004, 0);
        fetch(32'h0000_0008, 0);
        fetch(32'h0000_000C, 0);

        // Same index, different tag evicts; the original block misses again.
        fetch(32'h0000_0080, 0);
        fetch(32'h0000_0084, 0);
        fetch(32'h0000_0000, 0);

        // PC wanders during a fill: only line 1 fills, line 7 stays cold.
        do_reset();
        fetch(32'h0000_0010, 1);
        fetch(32'h0000_0014, 0);
        fetch(32'h0000_03F0, 0);

        // Reset in mid-fill aborts it; the same fetch misses afterwards.
        do_reset();
        repeat (10) @(negedge CLK);
        fetch(32'h0000_0120, 2);
        fetch(32'h0000_0120, 0);
        fetch(32'h0000_0124, 0);

        // Randomized traffic; upper and byte-offset PC bits are garbage.
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[9:4] = 6'($urandom_range(0, 63));
            else                           r[9:4] = 6'($urandom_range(0, 15));
            if (mem_cnt == 0) mem_lat = $urandom_range(1, 6);
            fetch(r, ($urandom_range(0, 24) == 0) ? 2 : 0);
        end

        repeat (4) @(negedge CLK);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
